// File: rtl/imm_ext_ctrl.sv
// ---------------------------------------------------------------------------
// ImmExtCtrl: immediate-extension stage sitting between IF/ID and ID/EX.
// Decodes the extension kind of each incoming instruction at accept time and
// stores the extended immediate in a 2-entry in-order skid buffer, so the
// outputs come straight from registers.
//
// Ports
//   i_clock   : single clock, rising-edge active
//   i_reset   : synchronous active-high reset
//   i_valid   : upstream presents an instruction
//   i_instr   : instruction word (opcode [31:26], shamt [10:6], funct [5:0],
//               imm [15:0])
//   o_ready   : buffer can take an instruction this cycle
//   i_flush   : drop every buffered entry and the one presented this cycle
//   o_valid   : head entry is valid
//   i_ready   : downstream consumes the head entry
//   o_imm     : extended immediate of the head entry
//   o_kind    : extension kind of the head entry
//               (0 sign, 1 zero, 2 upper, 3 shamt)
// ---------------------------------------------------------------------------
module imm_ext_ctrl #(
  parameter int NB_DATA = 32,
  parameter int NB_IMM  = 16
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_instr,
  output logic               o_ready,
  input  logic               i_flush,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [NB_DATA-1:0] o_imm,
  output logic [1:0]         o_kind
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } BufState;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;

  localparam logic [1:0] KIND_SIGN  = 2'd0;
  localparam logic [1:0] KIND_ZERO  = 2'd1;
  localparam logic [1:0] KIND_UPPER = 2'd2;
  localparam logic [1:0] KIND_SHAMT = 2'd3;

  BufState r_state;
  BufState w_stateNext;

  logic [NB_DATA-1:0] r_headImm;
  logic [1:0]         r_headKind;
  logic [NB_DATA-1:0] r_tailImm;
  logic [1:0]         r_tailKind;

  logic [5:0]         w_opcode;
  logic [5:0]         w_funct;
  logic [4:0]         w_shamt;
  logic [NB_IMM-1:0]  w_imm;
  logic [NB_DATA-1:0] w_extImm;
  logic [1:0]         w_extKind;

  logic w_accept;
  logic w_emit;
  logic w_loadHeadNew;
  logic w_loadHeadTail;
  logic w_loadTail;
  logic w_unused;

  assign w_opcode = i_instr[NB_DATA-1 -: 6];
  assign w_funct  = i_instr[5:0];
  assign w_shamt  = i_instr[10:6];
  assign w_imm    = i_instr[NB_IMM-1:0];

  // The rs/rt register fields play no part in immediate extension.
  assign w_unused = &{1'b0, i_instr[NB_DATA-7:NB_IMM]};

  // Classify the incoming instruction and build its extended immediate.
  // Anything that is not a logical-immediate, LUI or constant shift falls
  // back to sign extension, including R-type instructions other than shifts.
  always_comb begin
    w_extImm  = {{(NB_DATA-NB_IMM){w_imm[NB_IMM-1]}}, w_imm};
    w_extKind = KIND_SIGN;
    if ((w_opcode == OP_ANDI) || (w_opcode == OP_ORI) || (w_opcode == OP_XORI)) begin
      w_extImm  = {{(NB_DATA-NB_IMM){1'b0}}, w_imm};
      w_extKind = KIND_ZERO;
    end else if (w_opcode == OP_LUI) begin
      w_extImm  = {w_imm, {(NB_DATA-NB_IMM){1'b0}}};
      w_extKind = KIND_UPPER;
    end else if ((w_opcode == OP_SPECIAL) &&
                 ((w_funct == FN_SLL) || (w_funct == FN_SRL) || (w_funct == FN_SRA))) begin
      w_extImm  = {{(NB_DATA-5){1'b0}}, w_shamt};
      w_extKind = KIND_SHAMT;
    end
  end

  // Next-state and handshake logic. Ready/valid depend only on the state
  // register. When an accept and an emit coincide in ONE, the new entry
  // replaces the head directly; in FULL the tail slides into the head on
  // emit. A flush wins over everything and suppresses all data loads.
  always_comb begin
    w_stateNext    = r_state;
    w_loadHeadNew  = 1'b0;
    w_loadHeadTail = 1'b0;
    w_loadTail     = 1'b0;
    o_ready        = (r_state != FULL);
    o_valid        = (r_state != EMPTY);
    w_accept       = i_valid && o_ready;
    w_emit         = o_valid && i_ready;

    if (i_flush) begin
      w_stateNext = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_stateNext   = ONE;
            w_loadHeadNew = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_emit) begin
            w_loadHeadNew = 1'b1;
          end else if (w_accept) begin
            w_stateNext = FULL;
            w_loadTail  = 1'b1;
          end else if (w_emit) begin
            w_stateNext = EMPTY;
          end
        end
        FULL: begin
          if (w_emit) begin
            w_stateNext    = ONE;
            w_loadHeadTail = 1'b1;
          end
        end
        default: begin
          w_stateNext = EMPTY;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Entry storage. Reset clears both slots so the head reads as zero.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_headImm  <= '0;
      r_headKind <= KIND_SIGN;
      r_tailImm  <= '0;
      r_tailKind <= KIND_SIGN;
    end else begin
      if (w_loadHeadNew) begin
        r_headImm  <= w_extImm;
        r_headKind <= w_extKind;
      end else if (w_loadHeadTail) begin
        r_headImm  <= r_tailImm;
        r_headKind <= r_tailKind;
      end
      if (w_loadTail) begin
        r_tailImm  <= w_extImm;
        r_tailKind <= w_extKind;
      end
    end
  end

  assign o_imm  = r_headImm;
  assign o_kind = r_headKind;

endmodule

// File: tb/tb_imm_ext_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imm_ext_ctrl: directed self-checking bench for imm_ext_ctrl.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_imm_ext_ctrl;

  logic        i_clock;
  logic        i_reset;
  logic        i_valid;
  logic [31:0] i_instr;
  logic        o_ready;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_imm;
  logic [1:0]  o_kind;

  int nCompared;
  int nMismatched;

  logic [31:0] vecInstr [11];
  logic [31:0] vecImm   [11];
  logic [1:0]  vecKind  [11];

  imm_ext_ctrl #(
    .NB_DATA(32),
    .NB_IMM (16)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_valid(i_valid),
    .i_instr(i_instr),
    .o_ready(o_ready),
    .i_flush(i_flush),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_imm  (o_imm),
    .o_kind (o_kind)
  );

  // Free-running 10-unit clock.
  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  // Hand-computed instruction vectors and their expected extensions.
  task automatic loadVectors();
    vecInstr[0]  = 32'h20018004; vecImm[0]  = 32'hFFFF8004; vecKind[0]  = 2'd0;
    vecInstr[1]  = 32'h34008004; vecImm[1]  = 32'h00008004; vecKind[1]  = 2'd1;
    vecInstr[2]  = 32'h3C001234; vecImm[2]  = 32'h12340000; vecKind[2]  = 2'd2;
    vecInstr[3]  = 32'h00000140; vecImm[3]  = 32'h00000005; vecKind[3]  = 2'd3;
    vecInstr[4]  = 32'h20007FFF; vecImm[4]  = 32'h00007FFF; vecKind[4]  = 2'd0;
    vecInstr[5]  = 32'h000007C2; vecImm[5]  = 32'h0000001F; vecKind[5]  = 2'd3;
    vecInstr[6]  = 32'h00008020; vecImm[6]  = 32'hFFFF8020; vecKind[6]  = 2'd0;
    vecInstr[7]  = 32'h3000FFFF; vecImm[7]  = 32'h0000FFFF; vecKind[7]  = 2'd1;
    vecInstr[8]  = 32'h3800F234; vecImm[8]  = 32'h0000F234; vecKind[8]  = 2'd1;
    vecInstr[9]  = 32'h00000003; vecImm[9]  = 32'h00000000; vecKind[9]  = 2'd3;
    vecInstr[10] = 32'h00008001; vecImm[10] = 32'hFFFF8001; vecKind[10] = 2'd0;
  endtask

  // Reset while upstream is pushing; head must read empty and zero.
  task automatic test_reset();
    i_reset = 1'b1; i_valid = 1'b1; i_instr = vecInstr[0]; i_flush = 1'b0; i_ready = 1'b1;
    tick();
    tick();
    i_reset = 1'b0; i_valid = 1'b0;
    nCompared++;
    if (o_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid got %b want 0", o_valid); end
    nCompared++;
    if (o_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_ready got %b want 1", o_ready); end
    nCompared++;
    if (o_imm !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_imm got %h want 00000000", o_imm); end
    nCompared++;
    if (o_kind !== 2'd0) begin nMismatched++; $display("[TB] FAIL reset_kind got %0d want 0", o_kind); end
  endtask

  // ADDI 0x8004 appears one cycle after accept and stays exactly one cycle.
  task automatic test_latency();
    i_ready = 1'b1; i_valid = 1'b1; i_instr = vecInstr[0];
    tick();
    i_valid = 1'b0;
    nCompared++;
    if (o_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL lat_valid got %b want 1", o_valid); end
    nCompared++;
    if (o_imm !== 32'hFFFF8004) begin nMismatched++; $display("[TB] FAIL lat_imm got %h want ffff8004", o_imm); end
    nCompared++;
    if (o_kind !== 2'd0) begin nMismatched++; $display("[TB] FAIL lat_kind got %0d want 0", o_kind); end
    tick();
    nCompared++;
    if (o_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL lat_one_cycle got %b want 0", o_valid); end
  endtask

  // One instruction at a time through every extension kind.
  task automatic test_extension();
    i_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      i_valid = 1'b1; i_instr = vecInstr[k];
      tick();
      i_valid = 1'b0;
      nCompared++;
      if (o_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL ext_valid[%0d] got %b want 1", k, o_valid); end
      nCompared++;
      if (o_imm !== vecImm[k]) begin nMismatched++; $display("[TB] FAIL ext_imm[%0d] got %h want %h", k, o_imm, vecImm[k]); end
      nCompared++;
      if (o_kind !== vecKind[k]) begin nMismatched++; $display("[TB] FAIL ext_kind[%0d] got %0d want %0d", k, o_kind, vecKind[k]); end
      tick();
    end
  endtask

  // Continuous stream with i_ready high: accept and emit every cycle.
  task automatic test_throughput();
    i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      i_valid = 1'b1; i_instr = vecInstr[6+k];
      if (k > 0) begin
        nCompared++;
        if (o_valid !== 1'b1 || o_imm !== vecImm[5+k]) begin
          nMismatched++;
          $display("[TB] FAIL thru_head[%0d] got v=%b %h want v=1 %h", k, o_valid, o_imm, vecImm[5+k]);
        end
        nCompared++;
        if (o_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL thru_ready[%0d] got %b want 1", k, o_ready); end
      end
      tick();
    end
    i_valid = 1'b0;
    nCompared++;
    if (o_valid !== 1'b1 || o_imm !== vecImm[9] || o_kind !== vecKind[9]) begin
      nMismatched++;
      $display("[TB] FAIL thru_last got v=%b %h k=%0d want v=1 %h k=%0d", o_valid, o_imm, o_kind, vecImm[9], vecKind[9]);
    end
    tick();
    nCompared++;
    if (o_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL thru_drain got %b want 0", o_valid); end
  endtask

  // Fill with A and B under stall, try a third push, then drain in order.
  task automatic test_stall();
    i_ready = 1'b0;
    i_valid = 1'b1; i_instr = vecInstr[4];
    tick();
    nCompared++;
    if (o_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_ready_one got %b want 1", o_ready); end
    i_instr = vecInstr[1];
    tick();
    nCompared++;
    if (o_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_ready_full got %b want 0", o_ready); end
    i_instr = vecInstr[2];
    for (int k = 0; k < 3; k++) begin
      tick();
      nCompared++;
      if (o_valid !== 1'b1 || o_imm !== vecImm[4] || o_kind !== vecKind[4] || o_ready !== 1'b0) begin
        nMismatched++;
        $display("[TB] FAIL stall_hold[%0d] got v=%b r=%b %h k=%0d want v=1 r=0 %h k=%0d",
                 k, o_valid, o_ready, o_imm, o_kind, vecImm[4], vecKind[4]);
      end
    end
    i_valid = 1'b0; i_ready = 1'b1;
    tick();
    nCompared++;
    if (o_valid !== 1'b1 || o_imm !== vecImm[1] || o_kind !== vecKind[1]) begin
      nMismatched++;
      $display("[TB] FAIL stall_second got v=%b %h k=%0d want v=1 %h k=%0d", o_valid, o_imm, o_kind, vecImm[1], vecKind[1]);
    end
    tick();
    nCompared++;
    if (o_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_no_third got %b want 0", o_valid); end
  endtask

  // Flush from FULL with i_ready, and flush from ONE with an accept pending.
  task automatic test_flush();
    i_ready = 1'b0; i_valid = 1'b1; i_instr = vecInstr[0];
    tick();
    i_instr = vecInstr[2];
    tick();
    i_valid = 1'b0; i_flush = 1'b1; i_ready = 1'b1;
    tick();
    i_flush = 1'b0;
    nCompared++;
    if (o_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_full_valid got %b want 0", o_valid); end
    nCompared++;
    if (o_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL flush_full_ready got %b want 1", o_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      nCompared++;
      if (o_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_quiet[%0d] got %b want 0", k, o_valid); end
    end
    i_ready = 1'b0; i_valid = 1'b1; i_instr = vecInstr[3];
    tick();
    i_flush = 1'b1; i_instr = vecInstr[5];
    nCompared++;
    if (o_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL flush_one_ready got %b want 1", o_ready); end
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    nCompared++;
    if (o_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL flush_one_valid got %b want 0", o_valid); end
  endtask

  // Eight instructions with random downstream readiness against a scoreboard.
  task automatic test_back_to_back();
    int expQ[$];
    int idx;
    int emitted;
    int head;
    bit prevAccept;
    idx = 0; emitted = 0; prevAccept = 1'b0;
    for (int cyc = 0; cyc < 200 && emitted < 8; cyc++) begin
      i_ready = 1'($urandom_range(0, 1));
      i_valid = (idx < 8);
      i_instr = (idx < 8) ? vecInstr[idx] : 32'h0;
      if (prevAccept) begin
        nCompared++;
        if (o_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_gap cyc %0d got %b want 1", cyc, o_valid); end
      end
      if (o_valid === 1'b1 && i_ready) begin
        nCompared++;
        if (expQ.size() == 0) begin
          nMismatched++;
          $display("[TB] FAIL b2b_extra got %h want none", o_imm);
        end else begin
          head = expQ.pop_front();
          if (o_imm !== vecImm[head] || o_kind !== vecKind[head]) begin
            nMismatched++;
            $display("[TB] FAIL b2b_entry[%0d] got %h k=%0d want %h k=%0d", head, o_imm, o_kind, vecImm[head], vecKind[head]);
          end
        end
        emitted++;
      end
      if (i_valid && o_ready === 1'b1) begin
        expQ.push_back(idx);
        idx++;
        prevAccept = 1'b1;
      end else begin
        prevAccept = 1'b0;
      end
      tick();
    end
    i_valid = 1'b0; i_ready = 1'b0;
    nCompared++;
    if (emitted != 8) begin nMismatched++; $display("[TB] FAIL b2b_count got %0d want 8", emitted); end
  endtask

  // Reset in FULL discards both entries and zeroes the head.
  task automatic test_reset_full();
    i_ready = 1'b0; i_valid = 1'b1; i_instr = vecInstr[2];
    tick();
    i_instr = vecInstr[7];
    tick();
    i_valid = 1'b0; i_reset = 1'b1; i_ready = 1'b1;
    tick();
    i_reset = 1'b0;
    nCompared++;
    if (o_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstfull_valid got %b want 0", o_valid); end
    nCompared++;
    if (o_imm !== 32'h0 || o_kind !== 2'd0) begin nMismatched++; $display("[TB] FAIL rstfull_imm got %h k=%0d want 00000000 k=0", o_imm, o_kind); end
    nCompared++;
    if (o_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL rstfull_ready got %b want 1", o_ready); end
    tick();
    nCompared++;
    if (o_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rstfull_stale got %b want 0", o_valid); end
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    i_reset = 1'b1; i_valid = 1'b0; i_instr = 32'h0; i_flush = 1'b0; i_ready = 1'b0;
    loadVectors();
    test_reset();
    test_latency();
    test_extension();
    test_throughput();
    test_stall();
    test_flush();
    test_back_to_back();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
